// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding word
// fetch at a time and buffers returned instructions in a DEPTH-entry queue.
module if_prefetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = {XLEN{1'b0}},
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_DataReq,
  output logic [XLEN-1:0] o_MemAddr,
  input  logic            i_MemReady,
  input  logic [XLEN-1:0] i_DataBlock,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_ex_inst_addr,
  input  logic            i_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              PW      = AW + 1;
  localparam logic [PW:0]     DEPTH_W = (PW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [PW-1:0]   PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] fetch_pc_r, fetch_pc_s;
  logic [XLEN-1:0] mem_addr_r, mem_addr_s;
  logic            req_pending_r, req_pending_s;
  logic            squash_r, squash_s;
  logic            halted_r, halted_s;
  logic [PW-1:0]   head_r, head_s;
  logic [PW-1:0]   tail_r, tail_s;

  logic [XLEN-1:0] q_instr_r [DEPTH];
  logic [XLEN-1:0] q_pc_r    [DEPTH];
  logic            q_ex_r    [DEPTH];

  logic            wr_en_s;
  logic [AW-1:0]   wr_idx_s;
  logic [XLEN-1:0] wr_instr_s;
  logic [XLEN-1:0] wr_pc_s;
  logic            wr_ex_s;

  logic            valid_s;
  logic            pop_s;
  logic            resp_s;
  logic            accept_s;
  logic            pend_after_s;
  logic            misalign_s;
  logic [PW:0]     occ_s;

  assign valid_s      = (head_r != tail_r);
  assign pop_s        = valid_s & i_ready;
  assign resp_s       = req_pending_r & i_MemReady;
  assign accept_s     = resp_s & ~squash_r;
  assign pend_after_s = req_pending_r & ~i_MemReady;
  assign misalign_s   = (i_redirect_pc[1:0] != 2'b00);

  // Occupancy seen by the issue check: entries after this cycle's pop/push plus any request still in flight.
  assign occ_s = {1'b0, tail_r - head_r}
               - {{PW{1'b0}}, pop_s}
               + {{PW{1'b0}}, accept_s}
               + {{PW{1'b0}}, pend_after_s};

  // Next-state: redirect overrides queue traffic; otherwise push/pop and issue the next sequential fetch.
  always_comb begin
    fetch_pc_s    = fetch_pc_r;
    mem_addr_s    = mem_addr_r;
    req_pending_s = req_pending_r;
    squash_s      = squash_r;
    halted_s      = halted_r;
    head_s        = head_r;
    tail_s        = tail_r;
    wr_en_s       = 1'b0;
    wr_idx_s      = tail_r[AW-1:0];
    wr_instr_s    = i_DataBlock;
    wr_pc_s       = mem_addr_r;
    wr_ex_s       = 1'b0;

    if (i_redirect) begin
      head_s        = {PW{1'b0}};
      fetch_pc_s    = i_redirect_pc;
      req_pending_s = pend_after_s;
      // A held request must still complete; its data is discarded when it does.
      squash_s      = pend_after_s;
      if (misalign_s) begin
        tail_s     = PTR_ONE;
        halted_s   = 1'b1;
        wr_en_s    = 1'b1;
        wr_idx_s   = {AW{1'b0}};
        wr_instr_s = {XLEN{1'b0}};
        wr_pc_s    = i_redirect_pc;
        wr_ex_s    = 1'b1;
      end else begin
        tail_s   = {PW{1'b0}};
        halted_s = 1'b0;
        if (!pend_after_s) begin
          req_pending_s = 1'b1;
          mem_addr_s    = i_redirect_pc;
        end else begin
          req_pending_s = 1'b1;
        end
      end
    end else begin
      head_s = head_r + {{(PW-1){1'b0}}, pop_s};
      if (resp_s) begin
        req_pending_s = 1'b0;
        squash_s      = 1'b0;
        if (!squash_r) begin
          wr_en_s    = 1'b1;
          tail_s     = tail_r + PTR_ONE;
          fetch_pc_s = fetch_pc_r + PC_STEP;
        end else begin
          tail_s = tail_r;
        end
      end else begin
        tail_s = tail_r;
      end
      if (!pend_after_s && !halted_r && (occ_s < DEPTH_W)) begin
        req_pending_s = 1'b1;
        mem_addr_s    = fetch_pc_s;
      end else begin
        mem_addr_s = mem_addr_r;
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      fetch_pc_r    <= PC_RESET;
      mem_addr_r    <= PC_RESET;
      req_pending_r <= 1'b0;
      squash_r      <= 1'b0;
      halted_r      <= 1'b0;
      head_r        <= {PW{1'b0}};
      tail_r        <= {PW{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_s;
      mem_addr_r    <= mem_addr_s;
      req_pending_r <= req_pending_s;
      squash_r      <= squash_s;
      halted_r      <= halted_s;
      head_r        <= head_s;
      tail_r        <= tail_s;
    end
  end

  // Queue storage; cleared on reset so no stale payload survives.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_r[i] <= {XLEN{1'b0}};
        q_pc_r[i]    <= {XLEN{1'b0}};
        q_ex_r[i]    <= 1'b0;
      end
    end else if (wr_en_s) begin
      q_instr_r[wr_idx_s] <= wr_instr_s;
      q_pc_r[wr_idx_s]    <= wr_pc_s;
      q_ex_r[wr_idx_s]    <= wr_ex_s;
    end
  end

  assign o_DataReq      = req_pending_r;
  assign o_MemAddr      = mem_addr_r;
  assign o_valid        = valid_s;
  assign o_instr        = valid_s ? q_instr_r[head_r[AW-1:0]] : {XLEN{1'b0}};
  assign o_pc           = valid_s ? q_pc_r[head_r[AW-1:0]]    : {XLEN{1'b0}};
  assign o_ex_inst_addr = valid_s ? q_ex_r[head_r[AW-1:0]]    : 1'b0;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a fixed-latency memory responder
// driven from the stimulus thread.
module tb_if_prefetch;

  logic        i_clk;
  logic        i_rst;
  logic        o_DataReq;
  logic [31:0] o_MemAddr;
  logic        i_MemReady;
  logic [31:0] i_DataBlock;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_ex_inst_addr;
  logic        i_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;

  int errors = 0;
  int checks = 0;
  int lat    = 0;
  int wait_cnt = 0;

  if_prefetch #(.XLEN(32), .PC_RESET(32'h0000_0100), .DEPTH(4)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_DataReq      (o_DataReq),
    .o_MemAddr      (o_MemAddr),
    .i_MemReady     (i_MemReady),
    .i_DataBlock    (i_DataBlock),
    .o_valid        (o_valid),
    .o_instr        (o_instr),
    .o_pc           (o_pc),
    .o_ex_inst_addr (o_ex_inst_addr),
    .i_ready        (i_ready),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then play memory: respond on the (lat+1)-th cycle of a held request.
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
    if (o_DataReq) begin
      if (wait_cnt >= lat) begin
        i_MemReady  = 1'b1;
        i_DataBlock = {16'hDEAD, o_MemAddr[15:0]};
        wait_cnt    = 0;
      end else begin
        i_MemReady  = 1'b0;
        wait_cnt    = wait_cnt + 1;
      end
    end else begin
      i_MemReady = 1'b0;
      wait_cnt   = 0;
    end
  endtask

  task automatic do_reset(input string tag);
    i_rst      = 1'b0;
    i_redirect = 1'b0;
    next_cycle();
    next_cycle();
    chk({tag, "_rst_req"},   32'(o_DataReq), 32'h0);
    chk({tag, "_rst_addr"},  o_MemAddr,      32'h0000_0100);
    chk({tag, "_rst_valid"}, 32'(o_valid),   32'h0);
    chk({tag, "_rst_pc"},    o_pc,           32'h0);
    i_rst = 1'b1;
  endtask

  initial begin
    i_rst         = 1'b0;
    i_MemReady    = 1'b0;
    i_DataBlock   = 32'h0;
    i_ready       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;

    // Zero-wait streaming, one instruction per cycle
    lat = 0; i_ready = 1'b1;
    do_reset("t1");
    next_cycle();
    chk("t1_req0",   32'(o_DataReq), 32'h1);
    chk("t1_addr0",  o_MemAddr,      32'h0000_0100);
    chk("t1_val0",   32'(o_valid),   32'h0);
    next_cycle();
    chk("t1_pc0",    o_pc,           32'h0000_0100);
    chk("t1_ins0",   o_instr,        32'hDEAD_0100);
    chk("t1_addr1",  o_MemAddr,      32'h0000_0104);
    next_cycle();
    chk("t1_pc1",    o_pc,           32'h0000_0104);
    chk("t1_addr2",  o_MemAddr,      32'h0000_0108);
    next_cycle();
    chk("t1_pc2",    o_pc,           32'h0000_0108);
    chk("t1_ex2",    32'(o_ex_inst_addr), 32'h0);

    // Consumer stalled: queue fills to DEPTH then fetch stops
    lat = 0; i_ready = 1'b0;
    do_reset("t2");
    repeat (5) next_cycle();
    chk("t2_full_req",  32'(o_DataReq), 32'h0);
    chk("t2_full_pc",   o_pc,           32'h0000_0100);
    repeat (2) next_cycle();
    chk("t2_hold_req",  32'(o_DataReq), 32'h0);
    chk("t2_hold_pc",   o_pc,           32'h0000_0100);
    i_ready = 1'b1;
    next_cycle();
    chk("t2_pop1_pc",   o_pc,           32'h0000_0104);
    chk("t2_resume_req",  32'(o_DataReq), 32'h1);
    chk("t2_resume_addr", o_MemAddr,      32'h0000_0110);
    next_cycle();
    chk("t2_pop2_pc",   o_pc,           32'h0000_0108);
    next_cycle();
    chk("t2_pop3_pc",   o_pc,           32'h0000_010C);
    next_cycle();
    chk("t2_new_pc",    o_pc,           32'h0000_0110);
    chk("t2_new_ins",   o_instr,        32'hDEAD_0110);

    // Redirect while a 3-cycle request is in flight: response squashed
    lat = 2; i_ready = 1'b1;
    do_reset("t3");
    repeat (7) next_cycle();
    chk("t3_pre_pc",    o_pc,           32'h0000_0104);
    chk("t3_pre_addr",  o_MemAddr,      32'h0000_0108);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
    next_cycle();
    i_redirect = 1'b0;
    chk("t3_flush_val", 32'(o_valid),   32'h0);
    chk("t3_held_req",  32'(o_DataReq), 32'h1);
    chk("t3_held_addr", o_MemAddr,      32'h0000_0108);
    next_cycle();
    chk("t3_held_addr2", o_MemAddr,     32'h0000_0108);
    next_cycle();
    chk("t3_tgt_addr",  o_MemAddr,      32'h0000_0200);
    chk("t3_drop_val",  32'(o_valid),   32'h0);
    repeat (2) next_cycle();
    chk("t3_wait_val",  32'(o_valid),   32'h0);
    next_cycle();
    chk("t3_first_val", 32'(o_valid),   32'h1);
    chk("t3_first_pc",  o_pc,           32'h0000_0200);
    chk("t3_first_ins", o_instr,        32'hDEAD_0200);

    // Misaligned redirect: fault entry, fetch halted until next redirect
    lat = 0; i_ready = 1'b0;
    do_reset("t4");
    next_cycle();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0202;
    next_cycle();
    i_redirect = 1'b0;
    chk("t4_ex_val",  32'(o_valid),        32'h1);
    chk("t4_ex_flag", 32'(o_ex_inst_addr), 32'h1);
    chk("t4_ex_pc",   o_pc,                32'h0000_0202);
    chk("t4_ex_ins",  o_instr,             32'h0);
    chk("t4_no_req",  32'(o_DataReq),      32'h0);
    repeat (2) next_cycle();
    chk("t4_held_flag", 32'(o_ex_inst_addr), 32'h1);
    chk("t4_held_req",  32'(o_DataReq),      32'h0);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300;
    next_cycle();
    i_redirect = 1'b0; i_ready = 1'b1;
    chk("t4_rs_val",  32'(o_valid),   32'h0);
    chk("t4_rs_flag", 32'(o_ex_inst_addr), 32'h0);
    chk("t4_rs_addr", o_MemAddr,      32'h0000_0300);
    chk("t4_rs_req",  32'(o_DataReq), 32'h1);
    next_cycle();
    chk("t4_rs_pc",   o_pc,           32'h0000_0300);
    chk("t4_rs_ex",   32'(o_ex_inst_addr), 32'h0);

    // Redirect coinciding with a response and a pop
    lat = 0; i_ready = 1'b1;
    do_reset("t5");
    next_cycle();
    next_cycle();
    chk("t5_pre_pc",  o_pc,           32'h0000_0100);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300;
    next_cycle();
    i_redirect = 1'b0;
    chk("t5_empty",   32'(o_valid),   32'h0);
    chk("t5_zero_pc", o_pc,           32'h0);
    chk("t5_addr",    o_MemAddr,      32'h0000_0300);
    chk("t5_req",     32'(o_DataReq), 32'h1);
    next_cycle();
    chk("t5_pc0",     o_pc,           32'h0000_0300);
    next_cycle();
    chk("t5_pc1",     o_pc,           32'h0000_0304);

    // Reset while a request is pending
    lat = 2; i_ready = 1'b1;
    do_reset("t6");
    next_cycle();
    chk("t6_req",     32'(o_DataReq), 32'h1);
    i_rst = 1'b0;
    next_cycle();
    chk("t6_rst_req", 32'(o_DataReq), 32'h0);
    chk("t6_rst_val", 32'(o_valid),   32'h0);
    i_rst = 1'b1;
    next_cycle();
    chk("t6_re_req",  32'(o_DataReq), 32'h1);
    chk("t6_re_addr", o_MemAddr,      32'h0000_0100);
    repeat (3) next_cycle();
    chk("t6_re_pc",   o_pc,           32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
